// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder producing {c, s} = a + b + c_0 one bit per
// clock by iterating a single-bit Full_Adder with a registered carry.
// Operands are loaded on the accepting edge (IDLE with start=1), fed into the
// cell LSB-first, and the sum bits are collected into an accumulator. The
// final result is latched into s/c on the last RUN edge, followed by a
// one-cycle done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request an addition; sampled only in IDLE
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   c_0    - carry-in, captured on the accepting edge
//   busy   - high while the operation is running
//   done   - one-cycle pulse when s/c hold a fresh result
//   s      - registered sum; holds the last result
//   c      - registered carry-out; holds the last result

module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic c_0,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ c_0;
  assign c = (a & b) | (c_0 & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_c;

  Full_Adder u_fa (
    .a   (ra_q[0]),
    .b   (rb_q[0]),
    .c_0 (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = c_0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 of the
        // operands has landed in acc[0].
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = {fa_s, acc_q[WIDTH-1:1]};
          c_d     = fa_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered decodes of the next state so they line up
    // with the state they describe.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;

endmodule
